ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 114 +++++++++++
 tb/tb_ps2_host_tx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device frame transmitter (inhibit, request-to-send, 8 data + odd parity + stop, ack check)
// Ports:
//   clk, reset            system clock, asynchronous active-low reset
//   tx_data, tx_valid     command byte and send request, accepted only while tx_ready
//   tx_ready, busy        idle / frame in progress
//   ps2_clk_in/data_in    raw PS/2 line levels
//   ps2_clk_oe/data_oe    1 pulls the corresponding open-drain line low
//   done, ack_ok, err     one-cycle end-of-frame pulse with sticky result flags
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       err
);
    localparam int CMAX = INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQUEST, SEND, ACK, WAIT_IDLE} state_t;
    state_t state, state_nx;

    logic [1:0]    clk_s, data_s;
    logic          clk_d;
    logic [9:0]    frame;
    logic [3:0]    idx;
    logic          cur_bit;
    logic [CW-1:0] cnt;
    logic          fe, line_idle, inhibit_end, timeout;

    assign fe          = clk_d & ~clk_s[1];
    assign line_idle   = clk_s[1] & data_s[1];
    assign inhibit_end = cnt == CW'(INHIBIT_CYCLES - 1);
    // a device edge in the same cycle as the limit counts as activity, not a timeout
    assign timeout     = (state inside {SEND, ACK, WAIT_IDLE}) && !fe && cnt == CW'(TIMEOUT_CYCLES);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = tx_valid ? INHIBIT : IDLE;
            INHIBIT:   state_nx = inhibit_end ? REQUEST : INHIBIT;
            REQUEST:   state_nx = SEND;
            SEND:      state_nx = timeout ? IDLE : (fe && idx == 4'd9) ? ACK : SEND;
            ACK:       state_nx = timeout ? IDLE : fe ? WAIT_IDLE : ACK;
            WAIT_IDLE: state_nx = (timeout || line_idle) ? IDLE : WAIT_IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        tx_ready    = state == IDLE;
        busy        = state != IDLE;
        ps2_clk_oe  = state == INHIBIT || state == REQUEST;
        // start bit is asserted in REQUEST and held until the first device edge
        ps2_data_oe = state == REQUEST || (state == SEND && !cur_bit);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s   <= 2'b11;
            data_s  <= 2'b11;
            clk_d   <= 1'b1;
            frame   <= '0;
            idx     <= '0;
            cur_bit <= 1'b1;
            cnt     <= '0;
            done    <= 1'b0;
            ack_ok  <= 1'b0;
            err     <= 1'b0;
        end else begin
            clk_s   <= {clk_s[0], ps2_clk_in};
            data_s  <= {data_s[0], ps2_data_in};
            clk_d   <= clk_s[1];
            done    <= timeout || (state == WAIT_IDLE && line_idle);
            // the inhibit hold pulls the clock low itself, so edges there must not disturb the count
            cnt     <= (state == IDLE || state == REQUEST || (fe && state != INHIBIT)) ? '0 : cnt + 1'b1;
            if (state == IDLE && tx_valid) begin
                frame  <= {1'b1, ~^tx_data, tx_data};
                ack_ok <= 1'b0;
                err    <= 1'b0;
            end
            if (state == REQUEST) begin
                idx     <= '0;
                cur_bit <= 1'b0;
            end else if (state == SEND && fe) begin
                idx     <= idx + 1'b1;
                cur_bit <= frame[idx];
            end
            if (state == ACK && fe) begin
                ack_ok <= ~data_s[1];
                err    <= data_s[1];
            end
            if (timeout) begin
                ack_ok <= 1'b0;
                err    <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with an open-drain PS/2 device model
module tb_ps2_host_tx;
    localparam int INH = 20;
    localparam int TMO = 300;
    localparam int H   = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, done, ack_ok, err, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       clk_line, data_line;

    assign clk_line  = ~ps2_clk_oe & dev_clk;
    assign data_line = ~ps2_data_oe & dev_data;

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk),
        .reset(reset),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .ps2_clk_in(clk_line),
        .ps2_data_in(data_line),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy(busy),
        .done(done),
        .ack_ok(ack_ok),
        .err(err)
    );

    int checks = 0;
    int fails = 0;
    int done_cnt = 0;
    logic last_ack = 1'b0;
    logic last_err = 1'b0;
    logic [1:0] last_oe = 2'b00;
    int inh_run = 0, inh_last = 0, inh_frames = 0, req_run = 0, req_last = 0;
    logic [10:0] bits;

    always @(negedge clk) begin
        if (done) begin
            done_cnt <= done_cnt + 1;
            last_ack <= ack_ok;
            last_err <= err;
            last_oe  <= {ps2_clk_oe, ps2_data_oe};
        end
        if (ps2_clk_oe && !ps2_data_oe) inh_run <= inh_run + 1;
        else if (inh_run != 0) begin
            inh_last   <= inh_run;
            inh_frames <= inh_frames + 1;
            inh_run    <= 0;
        end
        if (ps2_clk_oe && ps2_data_oe) req_run <= req_run + 1;
        else if (req_run != 0) begin
            req_last <= req_run;
            req_run  <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // device side: samples the data line while clock is high, before each falling edge
    task automatic dev(input int nfe, input logic ack_lvl, output logic [10:0] got);
        int n;
        n = 0;
        got = '0;
        while (!(busy && !ps2_clk_oe) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("clk_release", 32'(n < 200), 32'd1);
        for (int i = 0; i < nfe; i++) begin
            repeat (H) @(negedge clk);
            if (i < 11) got[i] = data_line;
            if (i == 10) dev_data = ack_lvl;
            repeat (2) @(negedge clk);
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
        end
        repeat (H) @(negedge clk);
        dev_data = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int exp, input int bound);
        int n;
        n = 0;
        while (done_cnt < exp && n < bound) begin
            @(posedge clk);
            n++;
        end
        repeat (5) @(posedge clk);
        check(tag, done_cnt, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #1;
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_done", done, 0);
        check("rst_ack_ok", ack_ok, 0);
        check("rst_err", err, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        send(8'hED);
        check("ed_busy", busy, 1);
        check("ed_clk_oe", ps2_clk_oe, 1);
        dev(11, 1'b0, bits);
        check("ed_bits", bits, 11'h7DA);
        wait_done("ed_done_cnt", 1, 600);
        check("ed_ack_ok", last_ack, 1);
        check("ed_err", last_err, 0);
        check("ed_inhibit_len", inh_last, INH);
        check("ed_request_len", req_last, 1);
        check("ed_tx_ready", tx_ready, 1);

        send(8'hF4);
        fork
            dev(11, 1'b0, bits);
            begin
                repeat (150) @(negedge clk);
                tx_data  = 8'h00;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        check("f4_bits", bits, 11'h5E8);
        wait_done("f4_done_cnt", 2, 600);
        check("f4_ack_ok", last_ack, 1);
        check("f4_err", last_err, 0);
        check("f4_inhibit_len", inh_last, INH);
        repeat (300) @(negedge clk);
        check("f4_no_second_frame", inh_frames, 2);
        check("f4_idle_busy", busy, 0);
        check("f4_no_extra_done", done_cnt, 2);

        send(8'h12);
        repeat (40) @(negedge clk);
        check("tmo_clk_oe", ps2_clk_oe, 0);
        check("tmo_start_held", ps2_data_oe, 1);
        wait_done("tmo_done_cnt", 3, 800);
        check("tmo_err", last_err, 1);
        check("tmo_ack_ok", last_ack, 0);
        check("tmo_oe", last_oe, 2'b00);

        send(8'h55);
        dev(11, 1'b1, bits);
        check("nak_bits", bits, 11'h6AA);
        wait_done("nak_done_cnt", 4, 600);
        check("nak_err", last_err, 1);
        check("nak_ack_ok", last_ack, 0);

        send(8'h2C);
        dev(5, 1'b1, bits);
        check("rstmid_bits", bits[4:0], 5'h18);
        check("rstmid_data_oe_before", ps2_data_oe, 1);
        reset = 1'b0;
        #1;
        check("rstmid_clk_oe", ps2_clk_oe, 0);
        check("rstmid_data_oe", ps2_data_oe, 0);
        check("rstmid_tx_ready", tx_ready, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (400) @(negedge clk);
        check("rstmid_no_done", done_cnt, 4);
        check("rstmid_ready_after", tx_ready, 1);
        check("rstmid_err_clear", err, 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
